// File: rtl/nibble_serial_addsub_ctrl_pkg.sv
// Shared types for the nibble-serial add/sub sequencer.
// State encoding and nibble width constant.
package nibble_serial_addsub_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int NIB_BITS = 4;

endpackage

// File: rtl/nibble_serial_addsub_ctrl_nibble_addsub.sv
// Combinational 4-bit ripple add slice.
// Exposes carry into bit 3 so the caller can derive signed overflow.
module nibble_addsub (
   input  logic [3:0] x,
   input  logic [3:0] y,
   input  logic       ci,
   output logic [3:0] s,
   output logic       c3,
   output logic       co
);

   logic [4:0] c;

   // ripple chain of four full adders
   always_comb begin
      c    = '0;
      s    = '0;
      c[0] = ci;
      for (int i = 0; i < 4; i++) begin
         s[i]   = x[i] ^ y[i] ^ c[i];
         c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
      end
   end

   assign c3 = c[3];
   assign co = c[4];

endmodule

// File: rtl/nibble_serial_addsub_ctrl.sv
// W-bit add/sub done one nibble per clock, LSB nibble first.
// Carry rides in a register between nibble cycles.
module nibble_serial_addsub_ctrl
   import nibble_serial_addsub_ctrl_pkg::*;
#(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic         op_sub,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic         ready,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] result,
   output logic         cout,
   output logic         ovf
);

   localparam int NIB = W / NIB_BITS;
   localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;

   if ((W % NIB_BITS) != 0 || W < NIB_BITS) begin : g_bad_w
      $error("W must be a multiple of 4 and at least 4");
   end

   state_t state;
   state_t state_nx;

   logic [CW-1:0]                    cnt;
   logic [NIB-1:0][NIB_BITS-1:0]     a_q;
   logic [NIB-1:0][NIB_BITS-1:0]     b_q;
   logic [NIB-1:0][NIB_BITS-1:0]     res_q;
   logic                             sub_q;
   logic                             carry_q;
   logic                             cout_q;
   logic                             ovf_q;

   logic [NIB_BITS-1:0] x;
   logic [NIB_BITS-1:0] y;
   logic [NIB_BITS-1:0] s;
   logic                c3;
   logic                co;
   logic                last;

   assign last = (cnt == CW'(NIB - 1));
   assign x    = a_q[cnt];
   assign y    = b_q[cnt] ^ {NIB_BITS{sub_q}};

   nibble_addsub u_slice (
      .x  (x),
      .y  (y),
      .ci (carry_q),
      .s  (s),
      .c3 (c3),
      .co (co)
   );

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // next-state: accept in IDLE, walk nibbles, one DONE cycle
   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (start) state_nx = RUN;
         RUN:     if (last)  state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // handshake outputs decoded from state
   always_comb begin
      ready = (state == IDLE);
      busy  = (state == RUN) || (state == DONE);
      done  = (state == DONE);
   end

   // operand latch, nibble counter, carry and result accumulation
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q     <= '0;
         b_q     <= '0;
         sub_q   <= 1'b0;
         carry_q <= 1'b0;
         cnt     <= '0;
         res_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (start) begin
                  a_q     <= a;
                  b_q     <= b;
                  sub_q   <= op_sub;
                  carry_q <= op_sub;
                  cnt     <= '0;
                  res_q   <= '0;
               end
            end
            RUN: begin
               res_q[cnt] <= s;
               carry_q    <= co;
               cnt        <= last ? '0 : cnt + 1'b1;
               if (last) begin
                  cout_q <= co;
                  ovf_q  <= c3 ^ co;
               end
            end
            default: ;
         endcase
      end
   end

   assign result = res_q;
   assign cout   = cout_q;
   assign ovf    = ovf_q;

endmodule

// File: tb/tb_nibble_serial_addsub_ctrl.sv
// Randomized bench for the nibble-serial add/sub sequencer.
// W=16 is checked cycle by cycle; W=4 and W=32 per operation.
module tb_nibble_serial_addsub_ctrl;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   logic        start = 1'b0;
   logic        op_sub = 1'b0;
   logic [15:0] a = '0;
   logic [15:0] b = '0;
   logic        ready, busy, done, cout, ovf;
   logic [15:0] result;

   logic        start4 = 1'b0;
   logic        op4 = 1'b0;
   logic [3:0]  a4 = '0;
   logic [3:0]  b4 = '0;
   logic        ready4, busy4, done4, cout4, ovf4;
   logic [3:0]  res4;

   logic        start32 = 1'b0;
   logic        op32 = 1'b0;
   logic [31:0] a32 = '0;
   logic [31:0] b32 = '0;
   logic        ready32, busy32, done32, cout32, ovf32;
   logic [31:0] res32;

   nibble_serial_addsub_ctrl #(.W(16)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .op_sub(op_sub),
      .a(a), .b(b), .ready(ready), .busy(busy), .done(done),
      .result(result), .cout(cout), .ovf(ovf)
   );

   nibble_serial_addsub_ctrl #(.W(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .start(start4), .op_sub(op4),
      .a(a4), .b(b4), .ready(ready4), .busy(busy4), .done(done4),
      .result(res4), .cout(cout4), .ovf(ovf4)
   );

   nibble_serial_addsub_ctrl #(.W(32)) dut32 (
      .clk(clk), .rst_n(rst_n), .start(start32), .op_sub(op32),
      .a(a32), .b(b32), .ready(ready32), .busy(busy32), .done(done32),
      .result(res32), .cout(cout32), .ovf(ovf32)
   );

   int checks = 0;
   int passes = 0;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // {ovf, cout, result} of a +/- b in w bits, straight from the arithmetic
   function automatic logic [33:0] ref_op(input int w, input logic sub,
                                          input logic [31:0] x,
                                          input logic [31:0] y);
      logic [32:0] m;
      logic [32:0] s;
      logic        xs, ys, rs;
      m = (33'd1 << w) - 33'd1;
      if (sub) s = ({1'b0, x} & m) + (~{1'b0, y} & m) + 33'd1;
      else     s = ({1'b0, x} & m) + ({1'b0, y} & m);
      xs = x[w-1];
      ys = y[w-1] ^ sub;
      rs = s[w-1];
      return {(xs == ys) && (rs != xs), s[w], s[31:0] & m[31:0]};
   endfunction

   // W=16 reference: edges since accept, pending and visible results
   int          k = 1000;
   logic [31:0] pend_x = '0;
   logic        pend_c = 1'b0;
   logic        pend_o = 1'b0;
   logic [15:0] shown_r = '0;
   logic        shown_c = 1'b0;
   logic        shown_o = 1'b0;
   logic [15:0] er16;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         k       <= 1000;
         pend_x  <= '0;
         pend_c  <= 1'b0;
         pend_o  <= 1'b0;
         shown_r <= '0;
         shown_c <= 1'b0;
         shown_o <= 1'b0;
      end else if (start && k > 4) begin
         {pend_o, pend_c, pend_x} <= ref_op(16, op_sub, {16'b0, a}, {16'b0, b});
         k <= 0;
      end else begin
         if (k < 1000) k <= k + 1;
         if (k == 3) begin
            shown_r <= pend_x[15:0];
            shown_c <= pend_c;
            shown_o <= pend_o;
         end
      end
   end

   // per-cycle comparison of the W=16 instance against the reference
   always @(negedge clk) begin
      if (rst_n) begin
         if (k < 4) er16 = pend_x[15:0] & 16'((32'd1 << (4 * k)) - 32'd1);
         else       er16 = shown_r;
         chk("ready16", ready, k > 4);
         chk("busy16", busy, k <= 4);
         chk("done16", done, k == 4);
         chk("result16", result, er16);
         chk("cout16", cout, shown_c);
         chk("ovf16", ovf, shown_o);
      end
   end

   task automatic op16(input logic sub, input logic [15:0] x,
                       input logic [15:0] y, input bit hold,
                       output int lat);
      int n;
      @(negedge clk);
      n = 0;
      while (!ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("ready_wait16", ready, 1);
      start  = 1'b1;
      op_sub = sub;
      a      = x;
      b      = y;
      lat    = 0;
      do begin
         @(negedge clk);
         lat++;
         a = 16'($urandom);
         b = 16'($urandom);
         if (hold) begin
            a      = 16'hFFFF;
            op_sub = ~sub;
         end else begin
            start = 1'b0;
         end
      end while (!done && lat < 20);
      start = 1'b0;
   endtask

   task automatic opw(input int w, input logic sub, input logic [31:0] x,
                      input logic [31:0] y);
      logic [33:0] e;
      logic [33:0] got;
      logic        d;
      int          n;
      e = ref_op(w, sub, x, y);
      @(negedge clk);
      if (w == 4) begin
         start4 = 1'b1; op4 = sub; a4 = x[3:0]; b4 = y[3:0];
      end else begin
         start32 = 1'b1; op32 = sub; a32 = x; b32 = y;
      end
      n = 0;
      d = 1'b0;
      while (!d && n < 50) begin
         @(negedge clk);
         n++;
         start4  = 1'b0;
         start32 = 1'b0;
         a4  = 4'($urandom);
         a32 = $urandom;
         d = (w == 4) ? done4 : done32;
      end
      got = (w == 4) ? {ovf4, cout4, 28'b0, res4} : {ovf32, cout32, res32};
      chk(w == 4 ? "lat4" : "lat32", n, w / 4 + 1);
      chk(w == 4 ? "res4" : "res32", got, e);
      @(negedge clk);
      chk(w == 4 ? "pulse4" : "pulse32", (w == 4) ? done4 : done32, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      int n;
      logic [33:0] m;

      m = ref_op(16, 1'b0, 32'h1234, 32'h0FFF);
      chk("model_add", m, {2'b00, 32'h2233});
      m = ref_op(16, 1'b1, 32'h8000, 32'h0001);
      chk("model_sub_ovf", m, {2'b11, 32'h7FFF});

      #13;
      chk("rst_result", result, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      #9 rst_n = 1'b1;
      @(negedge clk);
      chk("rst_ready", ready, 1);

      op16(1'b0, 16'h1234, 16'h0FFF, 1'b0, lat);
      chk("lat_add", lat, 5);
      chk("add_res", {cout, ovf, result}, {2'b00, 16'h2233});

      op16(1'b1, 16'h0005, 16'h0007, 1'b0, lat);
      chk("sub_borrow", {cout, ovf, result}, {2'b00, 16'hFFFE});
      op16(1'b1, 16'h0007, 16'h0005, 1'b0, lat);
      chk("sub_noborrow", {cout, ovf, result}, {2'b10, 16'h0002});

      op16(1'b0, 16'h7FFF, 16'h0001, 1'b0, lat);
      chk("add_ovf", {cout, ovf, result}, {2'b01, 16'h8000});
      op16(1'b1, 16'h8000, 16'h0001, 1'b0, lat);
      chk("sub_ovf", {cout, ovf, result}, {2'b11, 16'h7FFF});
      op16(1'b0, 16'hFFFF, 16'h0001, 1'b0, lat);
      chk("add_wrap", {cout, ovf, result}, {2'b10, 16'h0000});

      op16(1'b0, 16'h1111, 16'h2222, 1'b1, lat);
      chk("lat_hold", lat, 5);
      chk("hold_res", result, 16'h3333);
      @(negedge clk);
      chk("hold_single_done", done, 0);

      @(negedge clk);
      start = 1'b1; op_sub = 1'b0; a = 16'h0101; b = 16'h0202;
      n = 0;
      do begin @(negedge clk); n++; end while (!done && n < 20);
      n = 0;
      do begin @(negedge clk); n++; end while (!done && n < 20);
      chk("b2b_gap", n, 6);
      start = 1'b0;

      op16(1'b0, 16'h4321, 16'h1234, 1'b0, lat);
      @(negedge clk);
      start = 1'b1; a = 16'hABCD; b = 16'h1357; op_sub = 1'b0;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("midrst_result", result, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_done", done, 0);
      chk("midrst_cout", cout, 0);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("midrst_ready", ready, 1);
      op16(1'b0, 16'h0001, 16'h0001, 1'b0, lat);
      chk("after_rst", result, 16'h0002);

      repeat (40) begin
         repeat ($urandom_range(0, 2)) @(negedge clk);
         op16(1'($urandom), 16'($urandom), 16'($urandom),
              ($urandom_range(0, 3) == 0), lat);
         chk("lat_rand16", lat, 5);
      end

      opw(4, 1'b0, 32'h7, 32'h1);
      opw(4, 1'b1, 32'h8, 32'h1);
      opw(32, 1'b0, 32'hFFFF_FFFF, 32'h1);
      opw(32, 1'b1, 32'h0, 32'h1);
      repeat (20) opw(4, 1'($urandom), $urandom, $urandom);
      repeat (20) opw(32, 1'($urandom), $urandom, $urandom);

      @(negedge clk);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
